// File: rtl/ic_cmd_master_pkg.sv
// Shared definitions for the command-driven AXI initiator: response codes,
// burst type, FSM state encoding and the response merge helper.
package ic_cmd_master_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  // The write path spans WADDR (address still pending, data may flow) and
  // WDATA (address done, data remaining).
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WDATA,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA,
    ST_DONE
  } state_t;

  // Response severity happens to follow the numeric encoding, so the worst
  // response is simply the larger code.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ic_cmd_master_wdog.sv
// Watchdog for the initiator's wait states. load reloads the counter to its
// terminal value; each enabled idle cycle counts down, and tc pulses on the
// (2**TO_BITS-1)-th consecutive idle cycle.
module ic_cmd_master_wdog #(
  parameter int TO_BITS = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count_en,
  output logic tc
);

  localparam logic [TO_BITS-1:0] CNT_ONE = TO_BITS'(1);

  logic [TO_BITS-1:0] cnt_reg;

  assign tc = count_en && !load && (cnt_reg == CNT_ONE);

  // Down-counter: reload on load, otherwise decrement while counting is enabled.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt_reg <= '1;
    end else if (count_en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_ONE;
    end
  end

endmodule

// File: rtl/ic_cmd_master.sv
// AXI initiator fed by a one-deep command port. Each accepted command issues
// one INCR burst (write or read) with a single transaction outstanding, and
// reports worst response, ID-mismatch/timeout flags and an XOR data checksum.
module ic_cmd_master
  import ic_cmd_master_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = 4,
  parameter int TO_BITS   = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  // command port
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_BITS-1:0]   cmd_addr,
  input  logic [3:0]             cmd_len,
  input  logic [ID_BITS-1:0]     cmd_id,
  input  logic [DATA_BITS-1:0]   cmd_seed,
  // write address channel
  output logic [ID_BITS-1:0]     AWID,
  output logic [ADDR_BITS-1:0]   AWADDR,
  output logic [3:0]             AWLEN,
  output logic [2:0]             AWSIZE,
  output logic [1:0]             AWBURST,
  output logic                   AWVALID,
  input  logic                   AWREADY,
  // write data channel
  output logic [DATA_BITS-1:0]   WDATA,
  output logic [DATA_BITS/8-1:0] WSTRB,
  output logic                   WLAST,
  output logic                   WVALID,
  input  logic                   WREADY,
  // write response channel
  input  logic [ID_BITS-1:0]     BID,
  input  logic [1:0]             BRESP,
  input  logic                   BVALID,
  output logic                   BREADY,
  // read address channel
  output logic [ID_BITS-1:0]     ARID,
  output logic [ADDR_BITS-1:0]   ARADDR,
  output logic [3:0]             ARLEN,
  output logic [2:0]             ARSIZE,
  output logic [1:0]             ARBURST,
  output logic                   ARVALID,
  input  logic                   ARREADY,
  // read data channel
  input  logic [ID_BITS-1:0]     RID,
  input  logic [DATA_BITS-1:0]   RDATA,
  input  logic [1:0]             RRESP,
  input  logic                   RLAST,
  input  logic                   RVALID,
  output logic                   RREADY,
  // completion
  output logic                   done,
  output logic [1:0]             done_resp,
  output logic [1:0]             done_err,
  output logic [DATA_BITS-1:0]   done_csum
);

  localparam logic [2:0] SIZE_CODE = 3'($clog2(DATA_BITS / 8));

  state_t                 state_reg, state_next;
  logic [ADDR_BITS-1:0]   addr_reg;
  logic [3:0]             len_reg;
  logic [ID_BITS-1:0]     id_reg;
  logic [DATA_BITS-1:0]   seed_reg;
  logic [3:0]             beat_reg;
  logic                   w_done_reg;
  logic [DATA_BITS-1:0]   csum_reg;
  logic [1:0]             resp_reg;
  logic [1:0]             err_reg;

  logic accept;
  logic aw_hs, w_hs, w_last_hs, b_hs, ar_hs, r_hs;
  logic any_hs, wait_state, wdog_tc;
  logic burst_len_bad;

  // Channel handshakes derived from state and slave inputs only, so the
  // next-state logic never loops back through its own outputs.
  assign accept    = (state_reg == ST_IDLE) && cmd_valid;
  assign aw_hs     = (state_reg == ST_WADDR) && AWREADY;
  assign w_hs      = (((state_reg == ST_WADDR) && !w_done_reg) || (state_reg == ST_WDATA)) && WREADY;
  assign w_last_hs = w_hs && (beat_reg == len_reg);
  assign b_hs      = (state_reg == ST_WRESP) && BVALID;
  assign ar_hs     = (state_reg == ST_RADDR) && ARREADY;
  assign r_hs      = (state_reg == ST_RDATA) && RVALID;
  assign any_hs    = aw_hs || w_hs || b_hs || ar_hs || r_hs;

  assign wait_state = (state_reg == ST_WADDR) || (state_reg == ST_WDATA) ||
                      (state_reg == ST_WRESP) || (state_reg == ST_RADDR) ||
                      (state_reg == ST_RDATA);

  // An RLAST on the wrong beat, or a missing RLAST on the expected last beat.
  assign burst_len_bad = (RLAST && (beat_reg != len_reg)) || (!RLAST && (beat_reg == len_reg));

  ic_cmd_master_wdog #(
    .TO_BITS (TO_BITS)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .load     (!wait_state || any_hs),
    .count_en (wait_state && !any_hs),
    .tc       (wdog_tc)
  );

  // Command fields drive the address channels directly; beat k carries seed + k.
  assign AWID      = id_reg;
  assign AWADDR    = addr_reg;
  assign AWLEN     = len_reg;
  assign AWSIZE    = SIZE_CODE;
  assign AWBURST   = BURST_INCR;
  assign ARID      = id_reg;
  assign ARADDR    = addr_reg;
  assign ARLEN     = len_reg;
  assign ARSIZE    = SIZE_CODE;
  assign ARBURST   = BURST_INCR;
  assign WDATA     = seed_reg + DATA_BITS'(beat_reg);
  assign WSTRB     = '1;
  assign WLAST     = (beat_reg == len_reg);
  assign done_resp = resp_reg;
  assign done_err  = err_reg;
  assign done_csum = csum_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and channel VALID/READY decode; a watchdog expiry overrides all.
  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    AWVALID    = 1'b0;
    WVALID     = 1'b0;
    BREADY     = 1'b0;
    ARVALID    = 1'b0;
    RREADY     = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_next = cmd_write ? ST_WADDR : ST_RADDR;
        end
      end
      ST_WADDR: begin
        AWVALID = 1'b1;
        WVALID  = !w_done_reg;
        if (aw_hs) begin
          state_next = (w_done_reg || w_last_hs) ? ST_WRESP : ST_WDATA;
        end
      end
      ST_WDATA: begin
        WVALID = 1'b1;
        if (w_last_hs) begin
          state_next = ST_WRESP;
        end
      end
      ST_WRESP: begin
        BREADY = 1'b1;
        if (b_hs) begin
          state_next = ST_DONE;
        end
      end
      ST_RADDR: begin
        ARVALID = 1'b1;
        if (ar_hs) begin
          state_next = ST_RDATA;
        end
      end
      ST_RDATA: begin
        RREADY = 1'b1;
        if (r_hs && RLAST) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (wdog_tc) begin
      state_next = ST_DONE;
    end
  end

  // Command capture on accept, then beat counting and status accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg   <= '0;
      len_reg    <= '0;
      id_reg     <= '0;
      seed_reg   <= '0;
      beat_reg   <= '0;
      w_done_reg <= 1'b0;
      csum_reg   <= '0;
      resp_reg   <= RESP_OKAY;
      err_reg    <= '0;
    end else if (accept) begin
      addr_reg   <= cmd_addr;
      len_reg    <= cmd_len;
      id_reg     <= cmd_id;
      seed_reg   <= cmd_seed;
      beat_reg   <= '0;
      w_done_reg <= 1'b0;
      csum_reg   <= '0;
      resp_reg   <= RESP_OKAY;
      err_reg    <= '0;
    end else begin
      if (w_hs || r_hs) begin
        beat_reg <= beat_reg + 4'd1;
      end
      if (w_last_hs) begin
        w_done_reg <= 1'b1;
      end
      if (w_hs) begin
        csum_reg <= csum_reg ^ WDATA;
      end
      if (r_hs) begin
        csum_reg <= csum_reg ^ RDATA;
        resp_reg <= resp_max(resp_max(resp_reg, RRESP),
                             burst_len_bad ? RESP_SLVERR : RESP_OKAY);
        if (RID != id_reg) begin
          err_reg[0] <= 1'b1;
        end
      end
      if (b_hs) begin
        resp_reg <= resp_max(resp_reg, BRESP);
        if (BID != id_reg) begin
          err_reg[0] <= 1'b1;
        end
      end
      if (wdog_tc) begin
        err_reg[1] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ic_cmd_master.sv
// Directed bench for ic_cmd_master: a cycle-stepped AXI slave driven from
// the main initial block, with hand-computed expectations per transaction.
module tb_ic_cmd_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [3:0]  cmd_id;
  logic [63:0] cmd_seed;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID, AWREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID, ARREADY;
  logic [3:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID, RREADY;
  logic        done;
  logic [1:0]  done_resp, done_err;
  logic [63:0] done_csum;

  int checks = 0;
  int errors = 0;
  bit t_done;
  int t_arv;

  ic_cmd_master #(
    .ADDR_BITS (32),
    .DATA_BITS (64),
    .ID_BITS   (4),
    .TO_BITS   (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_id    (cmd_id),
    .cmd_seed  (cmd_seed),
    .AWID      (AWID),
    .AWADDR    (AWADDR),
    .AWLEN     (AWLEN),
    .AWSIZE    (AWSIZE),
    .AWBURST   (AWBURST),
    .AWVALID   (AWVALID),
    .AWREADY   (AWREADY),
    .WDATA     (WDATA),
    .WSTRB     (WSTRB),
    .WLAST     (WLAST),
    .WVALID    (WVALID),
    .WREADY    (WREADY),
    .BID       (BID),
    .BRESP     (BRESP),
    .BVALID    (BVALID),
    .BREADY    (BREADY),
    .ARID      (ARID),
    .ARADDR    (ARADDR),
    .ARLEN     (ARLEN),
    .ARSIZE    (ARSIZE),
    .ARBURST   (ARBURST),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .RID       (RID),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RLAST     (RLAST),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .done      (done),
    .done_resp (done_resp),
    .done_err  (done_err),
    .done_csum (done_csum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_slave();
    AWREADY = 1'b0; WREADY = 1'b0;
    BVALID = 1'b0; BID = '0; BRESP = '0;
    ARREADY = 1'b0;
    RVALID = 1'b0; RLAST = 1'b0; RDATA = '0; RRESP = '0; RID = '0;
  endtask

  task automatic check_reset(input string tag);
    $display("[%0t] %s: reset-value check", $time, tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_valids"}, 64'({AWVALID, WVALID, ARVALID}), 64'd0);
    check({tag, "_readys"}, 64'({BREADY, RREADY}), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_done_status"}, 64'({done_resp, done_err}), 64'd0);
    check({tag, "_done_csum"}, done_csum, 64'd0);
    check({tag, "_addr_id_len"}, 64'({ARADDR, ARID, ARLEN}), 64'd0);
    check({tag, "_wdata"}, WDATA, 64'd0);
  endtask

  // Issue one command and act as the slave until done (or a reset abort).
  // rmode: 0 = decode-error responder, 1 = one-hot data with RRESP 01 then 10,
  // 2 = one-hot data with OKAY.
  task automatic run_txn(input bit wr, input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [63:0] seed, input int aw_delay,
                         input logic [1:0] bresp, input bit ar_never, input logic [3:0] rid_off,
                         input int rmode, input int abort_at);
    int  beat = 0, rbeat = 0, lastw = -1, last_hs = -1;
    int  nbeats = int'(len) + 1;
    bit  aw_done = 0, ar_done = 0, b_done = 0, fin = 0;
    t_done = 0;
    t_arv  = 0;
    @(negedge clk);
    check("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_len = len; cmd_id = id; cmd_seed = seed;
    for (int cyc = 0; cyc < 1200 && !fin; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      idle_slave();
      if (cyc == 0) begin
        check(wr ? "awvalid_latency" : "arvalid_latency", 64'(wr ? AWVALID : ARVALID), 64'd1);
      end
      if (done) begin
        t_done = 1;
        fin = 1;
        if (last_hs >= 0) check("done_latency", 64'(cyc), 64'(last_hs + 1));
      end else if (wr) begin
        if (!aw_done) begin
          check("awvalid_held", 64'(AWVALID), 64'd1);
          check("bready_before_aw", 64'(BREADY), 64'd0);
        end
        if (aw_done && beat == nbeats && !b_done) begin
          BVALID = 1'b1; BID = id; BRESP = bresp;
        end
        AWREADY = (aw_delay < 0) || (lastw >= 0 && cyc >= lastw + aw_delay);
        WREADY  = 1'b1;
        if (AWVALID && AWREADY) begin
          check("aw_fields", 64'({AWADDR, AWID, AWLEN}), 64'({addr, id, len}));
          check("aw_size_burst", 64'({AWSIZE, AWBURST}), 64'({3'd3, 2'b01}));
          aw_done = 1;
        end
        if (WVALID) begin
          if (beat >= nbeats) begin
            check("wvalid_extra_beat", 64'(WVALID), 64'd0);
          end else begin
            check("wdata", WDATA, seed + 64'(beat));
            check("wlast", 64'(WLAST), 64'(beat == int'(len)));
            check("wstrb", 64'(WSTRB), 64'hFF);
            if (beat == int'(len)) lastw = cyc;
          end
          beat++;
        end
        if (BVALID && BREADY) begin
          b_done = 1;
          last_hs = cyc;
        end
      end else begin
        t_arv += int'(ARVALID);
        ARREADY = !ar_never;
        if (ar_done && rbeat < nbeats) begin
          RVALID = 1'b1;
          RID    = id + rid_off;
          RLAST  = (rbeat == nbeats - 1);
          RDATA  = (rmode == 0) ? 64'd0 : (64'd1 << rbeat);
          RRESP  = (rmode == 0) ? 2'b11 : (rmode == 1) ? ((rbeat < 8) ? 2'b01 : 2'b10) : 2'b00;
        end
        if (ARVALID && ARREADY) begin
          check("ar_fields", 64'({ARADDR, ARID, ARLEN}), 64'({addr, id, len}));
          check("ar_size_burst", 64'({ARSIZE, ARBURST}), 64'({3'd3, 2'b01}));
          ar_done = 1;
        end
        if (RVALID && RREADY) begin
          last_hs = cyc;
          if (rbeat == abort_at) begin
            reset = 1'b1;
            fin = 1;
          end
          rbeat++;
        end
      end
    end
    check("txn_completed_in_budget", 64'(fin), 64'd1);
  endtask

  // Checks the completion cycle's status, then the return to IDLE.
  task automatic check_done(input string tag, input logic [1:0] resp, input logic [1:0] err,
                            input logic [63:0] csum);
    $display("[%0t] %s: done=%0d resp=%0d err=%0d csum=0x%0h", $time, tag, t_done,
             done_resp, done_err, done_csum);
    check({tag, "_done_seen"}, 64'(t_done), 64'd1);
    check({tag, "_resp"}, 64'(done_resp), 64'(resp));
    check({tag, "_err"}, 64'(done_err), 64'(err));
    check({tag, "_csum"}, done_csum, csum);
    check({tag, "_cmd_ready_in_done"}, 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    check({tag, "_cmd_ready_after"}, 64'(cmd_ready), 64'd1);
    check({tag, "_status_held"}, 64'({done_resp, done_err}), 64'({resp, err}));
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_len = '0; cmd_id = '0; cmd_seed = '0;
    idle_slave();
    repeat (3) @(negedge clk);
    check_reset("por");
    reset = 1'b0;

    // Write len=3 seed 0x10, always-ready slave: csum 0x10^0x11^0x12^0x13 = 0.
    run_txn(1'b1, 4'h5, 32'h0000_1000, 4'd3, 64'h10, -1, 2'b00, 1'b0, 4'd0, 0, -1);
    check_done("wr_basic", 2'b00, 2'b00, 64'h0);

    // Read len=0 to decode-error responder.
    run_txn(1'b0, 4'h2, 32'hDEAD_0000, 4'd0, 64'h0, -1, 2'b00, 1'b0, 4'd0, 0, -1);
    check_done("rd_decerr", 2'b11, 2'b00, 64'h0);

    // Write len=2 with AWREADY 5 cycles after last W; csum 0x100^0x101^0x102 = 0x103.
    run_txn(1'b1, 4'h9, 32'h0000_2000, 4'd2, 64'h100, 5, 2'b01, 1'b0, 4'd0, 0, -1);
    check_done("wr_aw_late", 2'b01, 2'b00, 64'h103);
    repeat (3) begin
      @(negedge clk);
      check("wr_aw_late_no_second_done", 64'(done), 64'd0);
    end

    // Read len=15, RID = ID+1, RRESP 01 then 10, data 1<<k: csum 0xFFFF.
    run_txn(1'b0, 4'h7, 32'h0000_3000, 4'd15, 64'h0, -1, 2'b00, 1'b0, 4'd1, 1, -1);
    check_done("rd_idmis", 2'b10, 2'b01, 64'hFFFF);

    // ARREADY never: 1023 wait cycles with ARVALID high, then timeout done.
    run_txn(1'b0, 4'h3, 32'h0000_4000, 4'd1, 64'h0, -1, 2'b00, 1'b1, 4'd0, 2, -1);
    check("timeout_arvalid_cycles", 64'(t_arv), 64'd1023);
    check("timeout_arvalid_low_at_done", 64'(ARVALID), 64'd0);
    check_done("rd_timeout", 2'b00, 2'b10, 64'h0);

    // Reset during beat 7 of a 16-beat read.
    run_txn(1'b0, 4'hA, 32'h0000_5000, 4'd15, 64'h0, -1, 2'b00, 1'b0, 4'd0, 2, 7);
    @(negedge clk);
    idle_slave();
    check_reset("after_abort");
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
    end

    // Recovery write; seed + 1 wraps to 0, csum = all ones.
    run_txn(1'b1, 4'h1, 32'h0000_6000, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, -1, 2'b00, 1'b0, 4'd0, 0, -1);
    check_done("wr_recover", 2'b00, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
